sng_arbiter: RTL and testbench

Round-robin burst arbiter and sequencer that shares one stochastic number generator (SNG) between NUM_REQ weight producers. It grants one requester per burst and forwards that requester's QUANT-bit weights to the SNG as w_data/w_valid/wlast. It captures each resulting bitstream in a single registered output stage, tagged with requester id, phase index and last flag. It sits between the weight-fetch units and the stochastic compute array.

---
 rtl/sng_arbiter.sv | 123 ++++++++++++
 tb/tb_sng_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sng_arbiter.sv
// Round-robin burst arbiter that time-shares one stochastic number generator
// between NUM_REQ weight producers and registers each resulting bitstream.
module sng_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BITSTREAM = 64,
  parameter int QUANT     = 8,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*QUANT-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [QUANT-1:0]         sng_w_data,
  output logic                     sng_w_valid,
  output logic                     sng_r_ready,
  output logic                     sng_wlast,
  input  logic [BITSTREAM-1:0]     sng_r_bitstream,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BITSTREAM-1:0]     out_bitstream,
  output logic [IDW-1:0]           out_id,
  output logic [1:0]               out_phase,
  output logic                     out_last
);

  // state | meaning
  // IDLE  | arbitrate among requesters, no beat accepted
  // BURST | stream beats of the granted requester into the SNG
  typedef enum logic {IDLE, BURST} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] grant, last_grant, pick;
  logic [IDW-1:0] idx;
  logic           found;
  logic [1:0]     phase;
  logic           any_req, slot_free, g_valid, g_last, acc;

  // Round-robin search starting just after the previous grant.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDW'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign any_req   = |req_valid;
  assign slot_free = !out_valid || out_ready;
  assign g_valid   = req_valid[grant];
  assign g_last    = req_last[grant];
  assign acc       = (state == BURST) && g_valid && slot_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    sng_w_data  = '0;
    sng_w_valid = 1'b0;
    sng_r_ready = 1'b0;
    sng_wlast   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = BURST;
      end
      BURST: begin
        req_ready[grant] = slot_free;
        sng_w_data       = req_data[int'(grant)*QUANT +: QUANT];
        sng_w_valid      = g_valid;
        sng_r_ready      = slot_free;
        sng_wlast        = acc && g_last;
        if (acc && g_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
    end else if (state == IDLE && any_req) begin
      grant      <= pick;
      last_grant <= pick;
    end
  end

  // Mirrors the SNG's internal k so each burst starts at phase 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         phase <= 2'd0;
    else if (sng_wlast) phase <= 2'd0;
    else if (acc)       phase <= phase + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_bitstream <= '0;
      out_id        <= '0;
      out_phase     <= 2'd0;
      out_last      <= 1'b0;
    end else if (acc) begin
      out_valid     <= 1'b1;
      out_bitstream <= sng_r_bitstream;
      out_id        <= grant;
      out_phase     <= phase;
      out_last      <= g_last;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sng_arbiter.sv
// Scoreboard bench for sng_arbiter: requester queues drive bursts, a monitor
// compares every consumed output beat against hand-computed expectations.
module tb_sng_arbiter;
  localparam int N  = 4;
  localparam int BS = 64;
  localparam int Q  = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0, req_last = '0, req_ready;
  logic [N*Q-1:0] req_data = '0;
  logic [Q-1:0]   sng_w_data;
  logic           sng_w_valid, sng_r_ready, sng_wlast;
  logic [BS-1:0]  sng_r_bitstream;
  logic           out_valid, out_last;
  logic           out_ready = 1'b1;
  logic [BS-1:0]  out_bitstream;
  logic [1:0]     out_id, out_phase;

  always #5 clk = ~clk;

  sng_arbiter #(.NUM_REQ(N), .BITSTREAM(BS), .QUANT(Q)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .sng_w_data(sng_w_data),
    .sng_w_valid(sng_w_valid), .sng_r_ready(sng_r_ready), .sng_wlast(sng_wlast),
    .sng_r_bitstream(sng_r_bitstream), .out_valid(out_valid), .out_ready(out_ready),
    .out_bitstream(out_bitstream), .out_id(out_id), .out_phase(out_phase),
    .out_last(out_last)
  );

  function automatic logic [63:0] bsf(input logic [7:0] d);
    return {8{d}} ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  assign sng_r_bitstream = bsf(sng_w_data);

  typedef struct packed { logic [7:0] d; logic last; } beat_t;
  typedef struct packed { logic [63:0] bs; logic [1:0] id; logic [1:0] ph; logic last; } exp_t;

  beat_t    rq[N][$];
  exp_t     sbq[$];
  int       oc[$];
  logic [N-1:0] hold = '0;
  logic [N-1:0] acc_s;
  int checks = 0, errors = 0;
  int cyc = 0, npop = 0, nwl = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic apply_drives();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0 && !hold[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*Q +: Q] = rq[i][0].d;
        req_last[i]        = rq[i][0].last;
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*Q +: Q] = '0;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic add_burst(input int id, input int n, input int base, input int step);
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      d = 8'(base + k*step);
      rq[id].push_back('{d: d, last: (k == n-1)});
      sbq.push_back('{bs: bsf(d), id: 2'(id), ph: 2'(k % 4), last: (k == n-1)});
    end
  endtask

  function automatic bit all_empty();
    bit e = (sbq.size() == 0);
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) e = 0;
    return e;
  endfunction

  task automatic wait_done(input string nm);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      if (all_empty()) break;
    end
    check({nm, "_pending"}, 64'(sbq.size()), 64'd0);
  endtask

  task automatic wait_pops(input int target);
    for (int c = 0; c < 100; c++) begin
      if (npop >= target) break;
      @(negedge clk); #1;
    end
    check("pop_wait", 64'(npop >= target), 64'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requester model: pop a beat after the edge where valid & ready was seen.
  always begin
    @(negedge clk);
    acc_s = req_valid & req_ready;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++)
      if (acc_s[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    apply_drives();
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sng_wlast) nwl++;
    if (rst_n && out_valid && out_ready) begin
      oc.push_back(cyc);
      npop++;
      if (sbq.size() == 0) begin
        check("unexpected_beat", 64'(out_id), 64'hFFFF);
      end else begin
        e = sbq.pop_front();
        check("out_bitstream", out_bitstream, e.bs);
        check("out_id", 64'(out_id), 64'(e.id));
        check("out_phase", 64'(out_phase), 64'(e.ph));
        check("out_last", 64'(out_last), 64'(e.last));
      end
    end
  end

  initial begin
    logic [BS-1:0] s_bs;
    logic [1:0] s_id, s_ph;
    logic s_last;
    int p0;

    // Reset state, with requests asserted during reset
    #1;
    req_valid = 4'hF;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_bitstream", out_bitstream, 64'd0);
    check("rst_out_id", 64'(out_id), 64'd0);
    check("rst_out_phase", 64'(out_phase), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_w_valid", 64'(sng_w_valid), 64'd0);
    check("rst_wlast", 64'(sng_wlast), 64'd0);
    req_valid = '0;
    @(negedge clk); #2;
    rst_n = 1'b1;

    // All four requesters, 2-beat bursts; requester 0 has a second burst
    oc.delete(); nwl = 0;
    add_burst(0, 2, 8'h01, 1);
    add_burst(1, 2, 8'h11, 1);
    add_burst(2, 2, 8'h21, 1);
    add_burst(3, 2, 8'h31, 1);
    add_burst(0, 2, 8'h41, 1);
    wait_done("rr4");
    check("rr4_wlast_count", 64'(nwl), 64'd5);
    if (oc.size() == 10)
      for (int j = 0; j < 9; j++)
        check($sformatf("rr4_gap%0d", j), 64'(oc[j+1] - oc[j]), (j % 2 == 0) ? 64'd1 : 64'd2);
    else
      check("rr4_beats", 64'(oc.size()), 64'd10);

    // Single requester 2, five weights
    oc.delete(); nwl = 0;
    add_burst(2, 5, 10, 10);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_valid[2]) break;
    end
    check("t1_ready_idle", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("t1_ready_grant", 64'(req_ready), 64'b0100);
    wait_done("t1");
    check("t1_wlast_count", 64'(nwl), 64'd1);
    check("t1_beats", 64'(oc.size()), 64'd5);
    if (oc.size() == 5)
      for (int j = 0; j < 4; j++)
        check($sformatf("t1_consec%0d", j), 64'(oc[j+1] - oc[j]), 64'd1);

    // Output backpressure for 3 cycles mid-burst
    p0 = npop;
    add_burst(1, 6, 8'h60, 1);
    wait_pops(p0 + 2);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    s_bs = out_bitstream; s_id = out_id; s_ph = out_phase; s_last = out_last;
    check("bp_out_valid", 64'(out_valid), 64'd1);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_r_ready", 64'(sng_r_ready), 64'd0);
      check("bp_bitstream", out_bitstream, s_bs);
      check("bp_id_phase_last", {59'd0, out_id, out_phase, out_last}, {59'd0, s_id, s_ph, s_last});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done("bp");

    // Granted requester drops valid for two cycles
    p0 = npop;
    add_burst(3, 5, 8'h70, 1);
    wait_pops(p0 + 2);
    @(posedge clk); #2;
    hold[3] = 1'b1;
    apply_drives();
    @(negedge clk); #1;
    check("hold_ready0", 64'(req_ready), 64'b1000);
    check("hold_wvalid0", 64'(sng_w_valid), 64'd0);
    @(negedge clk); #1;
    check("hold_ready1", 64'(req_ready), 64'b1000);
    check("hold_wvalid1", 64'(sng_w_valid), 64'd0);
    check("hold_no_beat", 64'(out_valid), 64'd0);
    @(posedge clk); #2;
    hold[3] = 1'b0;
    apply_drives();
    wait_done("hold");

    // Asynchronous reset mid-burst with internal phase 2
    p0 = npop;
    add_burst(0, 5, 8'h80, 1);
    wait_pops(p0 + 2);
    check("pre_rst_phase", 64'(out_phase), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_fields", {out_bitstream[59:0], out_id, out_phase},
          64'd0);
    check("arst_out_last", 64'(out_last), 64'd0);
    check("arst_req_ready", 64'(req_ready), 64'd0);
    check("arst_w_valid", 64'(sng_w_valid), 64'd0);
    @(posedge clk); #2;
    for (int i = 0; i < N; i++) rq[i].delete();
    sbq.delete();
    apply_drives();
    @(negedge clk); #2;
    rst_n = 1'b1;
    add_burst(0, 5, 8'h90, 1);
    add_burst(3, 1, 8'hA0, 1);
    wait_done("post_rst");

    // Simultaneous single-beat bursts from requesters 1 and 3
    oc.delete(); nwl = 0;
    add_burst(1, 1, 8'hB0, 1);
    add_burst(3, 1, 8'hC0, 1);
    wait_done("single");
    check("single_wlast_count", 64'(nwl), 64'd2);
    if (oc.size() == 2) check("single_gap", 64'(oc[1] - oc[0]), 64'd2);
    else                check("single_beats", 64'(oc.size()), 64'd2);

    repeat (3) @(negedge clk);
    check("final_idle_valid", 64'(out_valid), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
